// File: rtl/blur_pkg.sv
// Shared types and constants for the horizontal 1-2-1 blur stage.
package blur_pkg;

   localparam int PIX_W          = 8;
   localparam int SUM_W          = 10;
   localparam int DEF_LINE_WIDTH = 640;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } blur_state_t;

endpackage

// File: rtl/blur_kernel.sv
// Combinational 1-2-1 kernel with rounding; passes the centre pixel through in bypass.
module blur_kernel
   import blur_pkg::*;
(
   input  logic [PIX_W-1:0] i_left,
   input  logic [PIX_W-1:0] i_center,
   input  logic [PIX_W-1:0] i_right,
   input  logic             i_blur,
   output logic [PIX_W-1:0] o_pix
);

   logic [SUM_W-1:0] w_sum;

   // Worst case 255+510+255+2 = 1022 fits in SUM_W bits, so >>2 never exceeds 255.
   assign w_sum = SUM_W'(i_left) + SUM_W'({i_center, 1'b0}) + SUM_W'(i_right) + SUM_W'(2);
   assign o_pix = i_blur ? w_sum[SUM_W-1:2] : i_center;

endmodule

// File: rtl/blur_filter.sv
// Horizontal 1-2-1 blur with edge replication and a one-slot output register.
// Optional macro BLUR_BPM_GATE_EN gates blurring on BPM_estimate >= BPM_THRESH.
module blur_filter
   import blur_pkg::*;
#(
   parameter int LINE_WIDTH = DEF_LINE_WIDTH,
   parameter int BPM_THRESH = 120
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             valid_in,
   output logic             module_ready,
   input  logic             filter_enable,
   input  logic [7:0]       BPM_estimate,
   output logic [PIX_W-1:0] pix_out,
   input  logic             output_ready,
   output logic             valid_out
);

   localparam int             X_W    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam logic [X_W-1:0] X_LAST = X_W'(LINE_WIDTH - 1);
   localparam logic [X_W-1:0] X_ONE  = X_W'(1);

   blur_state_t      r_state;
   logic [X_W-1:0]   r_x;
   logic [PIX_W-1:0] r_prev;
   logic [PIX_W-1:0] r_cur;
   logic             r_mode;
   logic             r_valid_out;
   logic [PIX_W-1:0] r_pix_out;

   logic             w_slot_free;
   logic             w_ready;
   logic             w_in_xfer;
   logic             w_flush_go;
   logic             w_load;
   logic             w_mode_sel;
   logic [PIX_W-1:0] w_left;
   logic [PIX_W-1:0] w_right;
   logic [PIX_W-1:0] w_result;

   // Handshake: a beat moves on a rising clk edge where valid and ready are both high;
   // valid_out/pix_out hold while stalled, and module_ready follows output_ready combinationally.
   assign w_slot_free = !r_valid_out || output_ready;
   assign w_ready     = (r_state != FLUSH) && w_slot_free;
   assign w_in_xfer   = valid_in && w_ready;
   assign w_flush_go  = (r_state == FLUSH) && w_slot_free;
   assign w_load      = ((r_state == RUN) && w_in_xfer) || w_flush_go;

`ifdef BLUR_BPM_GATE_EN
   logic [7:0] w_thresh;
   assign w_thresh   = BPM_THRESH[7:0];
   assign w_mode_sel = filter_enable && (BPM_estimate >= w_thresh);
`else
   logic w_unused_bpm;
   assign w_unused_bpm = ^{BPM_estimate, BPM_THRESH[7:0]};
   assign w_mode_sel   = filter_enable;
`endif

   // Left neighbour replicates the centre at column 0; right replicates it during FLUSH.
   always_comb begin
      w_left  = r_cur;
      w_right = r_cur;
      if (r_state == RUN) begin
         w_right = pix_in;
         if (r_x != X_ONE) begin
            w_left = r_prev;
         end
      end else if ((r_state == FLUSH) && (LINE_WIDTH > 1)) begin
         w_left = r_prev;
      end
   end

   blur_kernel u_kernel (
      .i_left   (w_left),
      .i_center (r_cur),
      .i_right  (w_right),
      .i_blur   (r_mode),
      .o_pix    (w_result)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= FILL;
         r_x     <= '0;
         r_prev  <= '0;
         r_cur   <= '0;
         r_mode  <= 1'b0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_in_xfer) begin
                  r_cur  <= pix_in;
                  r_mode <= w_mode_sel;
                  if (LINE_WIDTH == 1) begin
                     r_x     <= '0;
                     r_state <= FLUSH;
                  end else begin
                     r_x     <= X_ONE;
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               if (w_in_xfer) begin
                  r_prev <= r_cur;
                  r_cur  <= pix_in;
                  if (r_x == X_LAST) begin
                     r_x     <= '0;
                     r_state <= FLUSH;
                  end else begin
                     r_x <= r_x + X_ONE;
                  end
               end
            end
            FLUSH: begin
               if (w_slot_free) begin
                  r_state <= FILL;
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid_out <= 1'b0;
         r_pix_out   <= '0;
      end else if (w_load) begin
         r_valid_out <= 1'b1;
         r_pix_out   <= w_result;
      end else if (output_ready) begin
         r_valid_out <= 1'b0;
      end
   end

   assign module_ready = w_ready;
   assign valid_out    = r_valid_out;
   assign pix_out      = r_pix_out;

endmodule

// File: tb/tb_blur_filter.sv
// Directed bench for blur_filter with LINE_WIDTH=4; covers blur, bypass, stalls, line restart and reset.
module tb_blur_filter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] pix_in = 8'd0;
   logic       valid_in = 1'b0;
   logic       module_ready;
   logic       filter_enable = 1'b1;
   logic [7:0] bpm = 8'd0;
   logic [7:0] pix_out;
   logic       output_ready = 1'b1;
   logic       valid_out;

   int assert_cnt = 0;
   int fail_cnt = 0;

   logic [7:0] in_vec[$];
   logic       ordy_pat[$];
   logic       fen_pat[$];
   logic [7:0] got_q[$];
   logic       mr_tr[$];
   logic       vo_tr[$];
   logic [7:0] po_tr[$];

   always #5 clk = ~clk;

   blur_filter #(
      .LINE_WIDTH (4),
      .BPM_THRESH (120)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .pix_in        (pix_in),
      .valid_in      (valid_in),
      .module_ready  (module_ready),
      .filter_enable (filter_enable),
      .BPM_estimate  (bpm),
      .pix_out       (pix_out),
      .output_ready  (output_ready),
      .valid_out     (valid_out)
   );

   // Driver: streams in_vec, applies per-cycle output_ready/filter_enable patterns, records traces.
   task automatic run_stream(input int n_out, input int budget, output bit timed_out);
      int idx = 0;
      int cyc = 0;
      got_q.delete();
      mr_tr.delete();
      vo_tr.delete();
      po_tr.delete();
      @(posedge clk);
      #1;
      valid_in     = (in_vec.size() > 0);
      pix_in       = valid_in ? in_vec[0] : 8'd0;
      output_ready = (ordy_pat.size() > 0) ? ordy_pat[0] : 1'b1;
      if (fen_pat.size() > 0) filter_enable = fen_pat[0];
      while (got_q.size() < n_out && cyc < budget) begin
         @(negedge clk);
         mr_tr.push_back(module_ready);
         vo_tr.push_back(valid_out);
         po_tr.push_back(pix_out);
         if (valid_out && output_ready) got_q.push_back(pix_out);
         if (valid_in && module_ready) idx++;
         @(posedge clk);
         #1;
         cyc++;
         valid_in     = (idx < in_vec.size());
         pix_in       = valid_in ? in_vec[idx] : 8'd0;
         output_ready = (cyc < ordy_pat.size()) ? ordy_pat[cyc] : 1'b1;
         if (cyc < fen_pat.size()) filter_enable = fen_pat[cyc];
      end
      valid_in     = 1'b0;
      output_ready = 1'b1;
      timed_out    = (got_q.size() < n_out);
   endtask

   task automatic test_reset();
      @(negedge clk);
      assert_cnt++;
      if (valid_out !== 1'b0) begin
         fail_cnt++;
         $display("FAIL reset_valid_out got %b required 0", valid_out);
      end
      assert_cnt++;
      if (pix_out !== 8'd0) begin
         fail_cnt++;
         $display("FAIL reset_pix_out got %0d required 0", pix_out);
      end
      assert_cnt++;
      if (module_ready !== 1'b1) begin
         fail_cnt++;
         $display("FAIL reset_module_ready got %b required 1", module_ready);
      end
   endtask

   task automatic test_blur();
      logic [7:0] exp_q[$] = '{8'd10, 8'd40, 8'd80, 8'd110};
      bit to;
      in_vec = '{8'd0, 8'd40, 8'd80, 8'd120};
      ordy_pat.delete();
      fen_pat.delete();
      filter_enable = 1'b1;
      run_stream(4, 40, to);
      assert_cnt++;
      if (to) begin
         fail_cnt++;
         $display("FAIL blur_timeout got %0d outputs required 4", got_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         assert_cnt++;
         if (got_q[i] !== exp_q[i]) begin
            fail_cnt++;
            $display("FAIL blur_out[%0d] got %0d required %0d", i, got_q[i], exp_q[i]);
         end
      end
      assert_cnt++;
      if (vo_tr[1] !== 1'b0 || vo_tr[2] !== 1'b1) begin
         fail_cnt++;
         $display("FAIL blur_latency got valid_out %b%b at cycles 1,2 required 01", vo_tr[1], vo_tr[2]);
      end
      assert_cnt++;
      if (mr_tr[4] !== 1'b0 || mr_tr[3] !== 1'b1) begin
         fail_cnt++;
         $display("FAIL blur_flush_bubble got ready %b%b at cycles 3,4 required 10", mr_tr[3], mr_tr[4]);
      end
   endtask

   task automatic test_bypass();
      logic [7:0] exp_q[$] = '{8'd0, 8'd40, 8'd80, 8'd120};
      bit to;
      in_vec = '{8'd0, 8'd40, 8'd80, 8'd120};
      ordy_pat.delete();
      fen_pat.delete();
      filter_enable = 1'b0;
      run_stream(4, 40, to);
      filter_enable = 1'b1;
      assert_cnt++;
      if (to) begin
         fail_cnt++;
         $display("FAIL bypass_timeout got %0d outputs required 4", got_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         assert_cnt++;
         if (got_q[i] !== exp_q[i]) begin
            fail_cnt++;
            $display("FAIL bypass_out[%0d] got %0d required %0d", i, got_q[i], exp_q[i]);
         end
      end
      assert_cnt++;
      if (vo_tr[1] !== 1'b0 || vo_tr[2] !== 1'b1 || mr_tr[4] !== 1'b0) begin
         fail_cnt++;
         $display("FAIL bypass_latency got vo1=%b vo2=%b ready4=%b required 0 1 0", vo_tr[1], vo_tr[2], mr_tr[4]);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_q[$] = '{8'd10, 8'd40, 8'd80, 8'd110};
      bit to;
      in_vec   = '{8'd0, 8'd40, 8'd80, 8'd120};
      ordy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      fen_pat.delete();
      run_stream(4, 40, to);
      ordy_pat.delete();
      assert_cnt++;
      if (to) begin
         fail_cnt++;
         $display("FAIL bp_timeout got %0d outputs required 4", got_q.size());
      end
      for (int c = 2; c <= 6; c++) begin
         assert_cnt++;
         if (vo_tr[c] !== 1'b1 || po_tr[c] !== 8'd10 || mr_tr[c] !== 1'b0) begin
            fail_cnt++;
            $display("FAIL bp_hold[%0d] got vo=%b pix=%0d ready=%b required 1 10 0", c, vo_tr[c], po_tr[c], mr_tr[c]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         assert_cnt++;
         if (got_q[i] !== exp_q[i]) begin
            fail_cnt++;
            $display("FAIL bp_out[%0d] got %0d required %0d", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q[$] = '{8'd10, 8'd40, 8'd80, 8'd110, 8'd80, 8'd50, 8'd99, 8'd206};
      bit to;
      int zeros = 0;
      in_vec = '{8'd0, 8'd40, 8'd80, 8'd120, 8'd100, 8'd20, 8'd60, 8'd255};
      ordy_pat.delete();
      fen_pat.delete();
      run_stream(8, 60, to);
      assert_cnt++;
      if (to) begin
         fail_cnt++;
         $display("FAIL b2b_timeout got %0d outputs required 8", got_q.size());
      end
      for (int i = 0; i < 8; i++) begin
         assert_cnt++;
         if (got_q[i] !== exp_q[i]) begin
            fail_cnt++;
            $display("FAIL b2b_out[%0d] got %0d required %0d", i, got_q[i], exp_q[i]);
         end
      end
      foreach (mr_tr[c]) if (mr_tr[c] === 1'b0) zeros++;
      assert_cnt++;
      if (zeros != 2 || mr_tr[4] !== 1'b0 || mr_tr[9] !== 1'b0) begin
         fail_cnt++;
         $display("FAIL b2b_bubbles got %0d ready-low cycles (c4=%b c9=%b) required 2 at cycles 4,9", zeros, mr_tr[4], mr_tr[9]);
      end
   endtask

   task automatic test_reset_midline();
      logic [7:0] part[3] = '{8'd0, 8'd40, 8'd80};
      logic [7:0] exp_q[$] = '{8'd80, 8'd50, 8'd99, 8'd206};
      bit to;
      filter_enable = 1'b1;
      output_ready  = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1;
         pix_in   = part[i];
         @(posedge clk);
         #1;
      end
      valid_in = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      assert_cnt++;
      if (valid_out !== 1'b0 || pix_out !== 8'd0) begin
         fail_cnt++;
         $display("FAIL midreset_out got vo=%b pix=%0d required 0 0", valid_out, pix_out);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      in_vec = '{8'd100, 8'd20, 8'd60, 8'd255};
      ordy_pat.delete();
      fen_pat.delete();
      run_stream(4, 40, to);
      assert_cnt++;
      if (to) begin
         fail_cnt++;
         $display("FAIL midreset_timeout got %0d outputs required 4", got_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         assert_cnt++;
         if (got_q[i] !== exp_q[i]) begin
            fail_cnt++;
            $display("FAIL midreset_out[%0d] got %0d required %0d", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_mode_latch();
      logic [7:0] exp_blur[$] = '{8'd10, 8'd40, 8'd80, 8'd110};
      logic [7:0] exp_byp[$]  = '{8'd0, 8'd40, 8'd80, 8'd120};
      bit to;
      in_vec  = '{8'd0, 8'd40, 8'd80, 8'd120};
      ordy_pat.delete();
      fen_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      run_stream(4, 40, to);
      assert_cnt++;
      if (to) begin
         fail_cnt++;
         $display("FAIL latch_blur_timeout got %0d outputs required 4", got_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         assert_cnt++;
         if (got_q[i] !== exp_blur[i]) begin
            fail_cnt++;
            $display("FAIL latch_blur_out[%0d] got %0d required %0d", i, got_q[i], exp_blur[i]);
         end
      end
      fen_pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      run_stream(4, 40, to);
      fen_pat.delete();
      filter_enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         assert_cnt++;
         if (got_q[i] !== exp_byp[i]) begin
            fail_cnt++;
            $display("FAIL latch_byp_out[%0d] got %0d required %0d", i, got_q[i], exp_byp[i]);
         end
      end
   endtask

   task automatic test_bpm();
      logic [7:0] exp_blur[$] = '{8'd10, 8'd40, 8'd80, 8'd110};
      logic [7:0] exp_byp[$]  = '{8'd0, 8'd40, 8'd80, 8'd120};
      logic [7:0] bpm_vals[3] = '{8'd100, 8'd120, 8'd150};
      bit to;
      in_vec = '{8'd0, 8'd40, 8'd80, 8'd120};
      ordy_pat.delete();
      fen_pat.delete();
      filter_enable = 1'b1;
      for (int b = 0; b < 3; b++) begin
         bpm = bpm_vals[b];
         run_stream(4, 40, to);
         for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
`ifdef BLUR_BPM_GATE_EN
            e = (bpm_vals[b] >= 8'd120) ? exp_blur[i] : exp_byp[i];
`else
            e = exp_blur[i];
`endif
            assert_cnt++;
            if (got_q[i] !== e) begin
               fail_cnt++;
               $display("FAIL bpm%0d_out[%0d] got %0d required %0d", bpm_vals[b], i, got_q[i], e);
            end
         end
      end
      bpm = 8'd0;
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_blur();
      test_bypass();
      test_backpressure();
      test_back_to_back();
      test_reset_midline();
      test_mode_latch();
      test_bpm();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no completion required finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
